// File: rtl/online_digit_otfc.sv
// On-the-fly converter: MSD-first radix-2 signed digits to an (N+1)-bit two's-complement value.
// Optional OTFC_SIGN_CORRECT_EN: a set final_neg with the last digit selects Q-1 as the result.
module online_digit_otfc #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_digit_valid,
    input  logic         i_digit_plus,
    input  logic         i_digit_minus,
    input  logic         i_final_neg,
    output logic         o_digit_ready,
    output logic [N:0]   o_result,
    output logic         o_result_valid,
    output logic         o_busy
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e          r_state;
    logic [N:0]      r_q;
    logic [N:0]      r_qm;
    logic [CW-1:0]   r_cnt;
    logic [N:0]      r_result;
    logic            r_result_valid;
    logic            r_digit_ready;
    logic            r_busy;

    logic            w_pos;
    logic            w_neg;
    logic            w_accept;
    logic            w_last;
    logic [N:0]      w_q_nxt;
    logic [N:0]      w_qm_nxt;
    logic [N:0]      w_final;

    assign w_pos    = i_digit_plus & ~i_digit_minus;
    assign w_neg    = i_digit_minus & ~i_digit_plus;
    assign w_accept = i_digit_valid && (r_state == StCollect);
    assign w_last   = (r_cnt == CW'(N - 1));

    // Both candidates are pre-shifted; the digit only picks which source feeds each register.
    always_comb begin
        w_q_nxt  = {r_q[N-1:0], 1'b0};
        w_qm_nxt = {r_qm[N-1:0], 1'b1};
        if (w_pos) begin
            w_q_nxt  = {r_q[N-1:0], 1'b1};
            w_qm_nxt = {r_q[N-1:0], 1'b0};
        end else if (w_neg) begin
            w_q_nxt  = {r_qm[N-1:0], 1'b1};
            w_qm_nxt = {r_qm[N-1:0], 1'b0};
        end
    end

`ifdef OTFC_SIGN_CORRECT_EN
    assign w_final = i_final_neg ? w_qm_nxt : w_q_nxt;
`else
    logic w_unused_final_neg;
    assign w_unused_final_neg = i_final_neg;
    assign w_final            = w_q_nxt;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_q            <= '0;
            r_qm           <= '1;
            r_cnt          <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_digit_ready  <= 1'b0;
            r_busy         <= 1'b0;
        end else if (i_start) begin
            r_state        <= StCollect;
            r_q            <= '0;
            r_qm           <= '1;
            r_cnt          <= '0;
            r_result_valid <= 1'b0;
            r_digit_ready  <= 1'b1;
            r_busy         <= 1'b1;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (w_accept) begin
                        r_q   <= w_q_nxt;
                        r_qm  <= w_qm_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state        <= StDone;
                            r_result       <= w_final;
                            r_result_valid <= 1'b1;
                            r_digit_ready  <= 1'b0;
                            r_busy         <= 1'b0;
                        end
                    end
                end
                StIdle, StDone: ;
                default: begin
                    r_state       <= StIdle;
                    r_digit_ready <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign o_digit_ready  = r_digit_ready;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
endmodule

// File: doc/online_digit_otfc.md
# online_digit_otfc

On-the-fly converter for the online divider's output side. It accepts the MSD-first radix-2 signed-digit stream (plus/minus bit pair per digit, the same encoding the divider datapath consumes as x_value) and builds the conventional two's-complement value digit by digit using the Q/QM register pair. No carry-propagate addition is needed at the end. It sits between the divider's digit-selection stage and any downstream binary consumer. The final value is ready one cycle after the last digit is accepted.

## Interface
Parameters:
- N, default 8: number of signed digits per operand; result width is N+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a new conversion; accepted in any state.
- digit_valid  input  1  a digit is presented on digit_plus/digit_minus.
- digit_plus  input  1  positive component of the signed digit.
- digit_minus  input  1  negative component of the signed digit.
- final_neg  input  1  sign-of-final-residual flag, sampled with the N-th digit. Used only with OTFC_SIGN_CORRECT_EN.
- digit_ready  output  1  converter accepts a digit this cycle.
- result  output  N+1  two's-complement integer Q; the fraction value is result/2^N.
- result_valid  output  1  result is final.
- busy  output  1  a conversion is in progress.

## Operation
- Digit decode: 10 → +1; 01 → −1; 00 and 11 → 0.
- A digit is accepted when digit_valid && digit_ready.
- States:
  - IDLE: digit_ready=0. start → COLLECT.
  - COLLECT: digit_ready=1, busy=1. When the N-th digit is accepted → DONE.
  - DONE: result_valid=1, digit_ready=0. Held until start or rst. start → COLLECT.
- On start, from any state:
  - Q ← 0.
  - QM ← all ones (−1).
  - digit counter ← 0.
  - result_valid ← 0.
- Register update per accepted digit q (N+1-bit signed registers, left shift with the MSB discarded):
  - q = +1: Q ← {Q,1}; QM ← {Q,0}.
  - q = 0: Q ← {Q,0}; QM ← {QM,1}.
  - q = −1: Q ← {QM,1}; QM ← {QM,0}.
- Invariant after every accept: QM = Q − 1.
- The result range for N digits is [−(2^N−1), 2^N−1], so N+1 bits never overflow.
- The digit counter is ceil(log2(N+1)) bits wide and increments once per accept. The accept that makes it N is the last one.
- Digits presented in IDLE or DONE are ignored; state, counter and registers do not change.
- result is driven from the output register, which is loaded only on the transition into DONE. In IDLE and COLLECT it holds the previous value.

## Timing
- Reset (rst high at a clock edge) gives:
  - state IDLE;
  - Q=0, QM=all ones, counter=0;
  - result=0, result_valid=0, digit_ready=0, busy=0.
- rst has priority over start. Reset mid-conversion abandons it; no result_valid is produced.
- start at edge t gives digit_ready=1 from t+1. One digit per cycle at most; stalls (digit_valid low) are allowed in any cycle.
- Last digit accepted at edge t: result and result_valid are valid from t+1.
- start while in DONE: result_valid falls at the next edge.
- start in the same cycle as an accepted digit: start wins and the digit is discarded.

## Configuration
- OTFC_SIGN_CORRECT_EN defined:
  - final_neg is sampled together with the N-th digit.
  - If it is 1, result loads the N-th-digit QM update (= Q − 1) instead of Q. This is the one-ulp quotient correction when the final partial remainder is negative.
- OTFC_SIGN_CORRECT_EN undefined: final_neg is ignored and result always loads Q.

## Test plan
All cases use N=8.
- Reset: rst high for 2 cycles during COLLECT → result=9'h000, result_valid=0, digit_ready=0, busy=0. A following digit with no start is ignored.
- Digits +1,0,0,0,0,0,0,0 back-to-back → result=9'h080 (128), result_valid high exactly one cycle after the 8th digit.
- Digits −1,+1,0,0,0,0,0,0 with one idle cycle between each → result=9'h1C0 (−64). Check QM=Q−1 after every accept.
- Eight digits of −1 → result=9'h101 (−255). Eight digits encoded 11 → result=9'h000.
- Restart: start, 3 digits of +1, start again, then +1 followed by seven 0s → result=9'h080. A digit presented together with the second start is dropped.
- With OTFC_SIGN_CORRECT_EN: digits +1 followed by seven 0s, final_neg=1 on the 8th digit → result=9'h07F. Without the macro, the same stimulus → 9'h080.
